// File: rtl/pe_array_gate_sched_if.sv
// Gate descriptor handshake between a gate source and pe_array_gate_sched.
interface pe_array_gate_sched_if #(
  parameter int QW = 4
);
  logic          gate_valid;
  logic          gate_ready;
  logic [QW-1:0] gate_target;
  logic [31:0]   gate_op_in;

  modport master (
    output gate_valid,
    output gate_target,
    output gate_op_in,
    input  gate_ready
  );

  modport slave (
    input  gate_valid,
    input  gate_target,
    input  gate_op_in,
    output gate_ready
  );
endinterface

// File: rtl/pe_array_gate_sched.sv
// Single-qubit gate scheduler: walks every amplitude pair of the state vector
// in beats of N_PES pairs, issues reads, and replays each read beat as a
// write-back exactly MEM_LAT+PE_LAT cycles later. The gate op is held stable
// on pe_gate_op until the next valid descriptor is accepted.
module pe_array_gate_sched #(
  parameter  int N_QUBITS = 10,
  parameter  int N_PES    = 4,
  parameter  int MEM_LAT  = 1,
  parameter  int PE_LAT   = 2,
  localparam int QW       = $clog2(N_QUBITS + 1),
  localparam int PW       = N_QUBITS - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pe_array_gate_sched_if.slave    gate,
  output logic [31:0]             pe_gate_op,
  output logic                    rd_en,
  output logic [PW-1:0]           rd_pair_base,
  output logic [QW-1:0]           rd_target,
  output logic                    wr_en,
  output logic [PW-1:0]           wr_pair_base,
  output logic [QW-1:0]           wr_target,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int NP    = 1 << PW;
  localparam int BEATS = NP / N_PES;
  localparam int D     = MEM_LAT + PE_LAT;
  localparam int PL    = $clog2(N_PES);
  localparam int BW    = (PW > PL) ? PW - PL : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // One delay-line slot mirrors one read beat on its way to write-back.
  typedef struct packed {
    logic          valid;
    logic          last;
    logic [PW-1:0] base;
  } slot_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q;
  logic [QW-1:0]   tgt_q;
  logic            done_q, err_q;
  slot_t [D-1:0]   dl;
  slot_t           slot_in;

  logic accept, tgt_ok, last_beat, wr_last;

  assign accept    = gate.gate_valid & gate.gate_ready;
  assign tgt_ok    = gate.gate_target < QW'(N_QUBITS);
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign wr_last   = dl[D-1].last;

  // Next-state and FSM-derived outputs
  always_comb begin
    state_d         = state_q;
    gate.gate_ready = 1'b0;
    rd_en           = 1'b0;
    busy            = 1'b0;
    case (state_q)
      IDLE: begin
        gate.gate_ready = 1'b1;
        if (accept && tgt_ok) state_d = ISSUE;
      end
      ISSUE: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (wr_en && wr_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Beat counter: cleared while idle so every gate starts at pair 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          beat_q <= '0;
    else if (state_q == IDLE)            beat_q <= '0;
    else if (state_q == ISSUE && !last_beat) beat_q <= beat_q + BW'(1);
  end

  // Descriptor latch: only a valid target updates the op driven to the array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q      <= '0;
      pe_gate_op <= '0;
    end else if (accept && tgt_ok) begin
      tgt_q      <= gate.gate_target;
      pe_gate_op <= gate.gate_op_in;
    end
  end

  // One-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      err_q  <= accept && !tgt_ok;
      done_q <= (state_q == DRAIN) && wr_en && wr_last;
    end
  end

  assign err  = err_q;
  assign done = done_q;

  assign rd_pair_base  = rd_en ? (PW'(beat_q) << PL) : '0;
  assign rd_target     = rd_en ? tgt_q : '0;

  assign slot_in.valid = rd_en;
  assign slot_in.last  = rd_en && last_beat;
  assign slot_in.base  = rd_pair_base;

  // Write-side delay line; reset drops every in-flight write
  if (D == 1) begin : g_dl_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dl <= '0;
      else        dl[0] <= slot_in;
    end
  end else begin : g_dl_multi
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dl <= '0;
      else        dl <= {dl[D-2:0], slot_in};
    end
  end

  assign wr_en        = dl[D-1].valid;
  assign wr_pair_base = wr_en ? dl[D-1].base : '0;
  assign wr_target    = wr_en ? tgt_q : '0;

endmodule
